// File: rtl/demux_dispatcher.sv
// Registered 1:4 stream dispatcher: one holding register feeding four lanes,
// routed round-robin over enabled lanes or by a per-word destination tag.
module demux_dispatcher #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_dest,
    input  logic             mode,
    input  logic [3:0]       lane_en,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       lane_sel,
    output logic             busy,
    output logic [CNTW-1:0]  drop_cnt
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0] state;
    logic [1:0] ptr;
    logic [7:0] en_dbl;
    logic [3:0] en_rot;
    logic [1:0] rr_off;
    logic [1:0] rr_lane;
    logic [1:0] pick;
    logic       drain;
    logic       route_ok;
    logic       accept;
    logic       dest_ok;
    logic       load;
    logic       drop;

    // Rotate the enable mask so bit 0 is the lane right after the pointer.
    assign en_dbl = {lane_en, lane_en};
    assign en_rot = en_dbl[({1'b0, ptr} + 3'd1) +: 4];

    always_comb begin
        rr_off = 2'd0;
        if (en_rot[0])      rr_off = 2'd0;
        else if (en_rot[1]) rr_off = 2'd1;
        else if (en_rot[2]) rr_off = 2'd2;
        else if (en_rot[3]) rr_off = 2'd3;
    end

    assign rr_lane  = ptr + 2'd1 + rr_off;
    assign pick     = mode ? in_dest : rr_lane;

    assign drain    = (state == FULL) && out_valid[lane_sel]
                      && out_ready[lane_sel];
    assign route_ok = mode || (lane_en != 4'b0000);
    assign in_ready = ((state == EMPTY) || drain) && route_ok;
    assign accept   = in_valid && in_ready;
    assign dest_ok  = lane_en[in_dest];
    assign load     = accept && (!mode || dest_ok);
    assign drop     = accept && mode && !dest_ok;

    assign busy     = (state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 4'b0000;
            out_data  <= '0;
            lane_sel  <= 2'd0;
        end else begin
            unique case (1'b1)
                load: begin
                    state     <= FULL;
                    out_valid <= 4'b0001 << pick;
                    out_data  <= in_data;
                    lane_sel  <= pick;
                end
                (!load && drain): begin
                    state     <= EMPTY;
                    out_valid <= 4'b0000;
                end
                default: begin
                    state     <= state;
                    out_valid <= out_valid;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 2'd3;
        end else if (accept && !mode) begin
            ptr <= rr_lane;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != {CNTW{1'b1}})) begin
            drop_cnt <= drop_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_demux_dispatcher.sv
// Self-checking bench for demux_dispatcher: directed scenarios plus a
// randomized run against a queue-level reference model.
module tb_demux_dispatcher;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_dest;
    logic       mode;
    logic [3:0] lane_en;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data;
    logic [1:0] lane_sel;
    logic       busy;
    logic [7:0] drop_cnt;

    logic       in_ready2;
    logic [3:0] out_valid2;
    logic [7:0] out_data2;
    logic [1:0] lane_sel2;
    logic       busy2;
    logic [1:0] drop_cnt2;

    int total;
    int bad;

    demux_dispatcher #(.WIDTH(8), .CNTW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dest(in_dest),
        .mode(mode), .lane_en(lane_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .lane_sel(lane_sel),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    demux_dispatcher #(.WIDTH(8), .CNTW(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_dest(in_dest),
        .mode(mode), .lane_en(lane_en),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .lane_sel(lane_sel2),
        .busy(busy2), .drop_cnt(drop_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_dest   = 2'd0;
        mode      = 1'b0;
        lane_en   = 4'b1111;
        out_ready = 4'b1111;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (out_valid !== 4'b0000 || busy !== 1'b0 || out_data !== 8'h00
            || lane_sel !== 2'd0 || drop_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset: ov=%b busy=%b data=%h sel=%0d drop=%0d",
                     out_valid, busy, out_data, lane_sel, drop_cnt);
        end
    endtask

    task automatic test_rr_sweep();
        logic [7:0] words [5];
        int lanes [5];
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        lanes = '{0, 1, 2, 3, 0};
        mode = 1'b0; lane_en = 4'b1111; out_ready = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            #1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL rr_ready[%0d]: got=%b want=1", i, in_ready);
            end
            tick();
            total++;
            if (out_valid !== (4'b0001 << lanes[i]) || out_data !== words[i]
                || lane_sel !== 2'(lanes[i])) begin
                bad++;
                $display("FAIL rr_word[%0d]: ov=%b data=%h sel=%0d want lane %0d data %h",
                         i, out_valid, out_data, lane_sel, lanes[i], words[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rr_drain: busy=%b want=0", busy);
        end
    endtask

    task automatic test_masked_skip();
        logic [7:0] words [3];
        logic [3:0] ovs [3];
        words = '{8'hA0, 8'hA1, 8'hA2};
        ovs   = '{4'b0010, 4'b1000, 4'b0010};
        mode = 1'b0; lane_en = 4'b1010; out_ready = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            tick();
            total++;
            if (out_valid !== ovs[i] || out_data !== words[i]) begin
                bad++;
                $display("FAIL skip[%0d]: ov=%b data=%h want ov=%b data=%h",
                         i, out_valid, out_data, ovs[i], words[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [3:0] ens [5];
        ens = '{4'b1111, 4'b0000, 4'b0101, 4'b1000, 4'b0011};
        mode = 1'b0; lane_en = 4'b0100; out_ready = 4'b1011;
        in_valid = 1'b1; in_data = 8'h5C;
        tick();
        in_data = 8'h77;
        for (int i = 0; i < 5; i++) begin
            lane_en = ens[i];
            #1;
            total++;
            if (busy !== 1'b1 || out_valid !== 4'b0100 || out_data !== 8'h5C
                || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold[%0d]: busy=%b ov=%b data=%h rdy=%b",
                         i, busy, out_valid, out_data, in_ready);
            end
            tick();
        end
        lane_en = 4'b0001;
        out_ready = 4'b1111;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release_ready: got=%b want=1", in_ready);
        end
        tick();
        total++;
        if (out_valid !== 4'b0001 || out_data !== 8'h77 || busy !== 1'b1) begin
            bad++;
            $display("FAIL bp_reload: ov=%b data=%h want ov=0001 data=77",
                     out_valid, out_data);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_addressed_drop();
        do_reset();
        mode = 1'b1; lane_en = 4'b0111; out_ready = 4'b1111;
        in_valid = 1'b1; in_dest = 2'd3; in_data = 8'hD3;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL drop_ready: got=%b want=1", in_ready);
        end
        tick();
        total++;
        if (drop_cnt !== 8'd1 || out_valid !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL drop_word: drop=%0d ov=%b busy=%b want 1/0000/0",
                     drop_cnt, out_valid, busy);
        end
        in_dest = 2'd1; in_data = 8'hD1;
        tick();
        total++;
        if (out_valid !== 4'b0010 || out_data !== 8'hD1 || lane_sel !== 2'd1
            || drop_cnt !== 8'd1) begin
            bad++;
            $display("FAIL addr_word: ov=%b data=%h sel=%0d drop=%0d",
                     out_valid, out_data, lane_sel, drop_cnt);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_drop_saturation();
        do_reset();
        mode = 1'b1; lane_en = 4'b0111; out_ready = 4'b1111;
        in_dest = 2'd3;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
            total++;
            if (drop_cnt2 !== 2'((i > 3) ? 3 : i) || drop_cnt !== 8'(i)) begin
                bad++;
                $display("FAIL sat[%0d]: cnt2=%0d cnt8=%0d want %0d/%0d",
                         i, drop_cnt2, drop_cnt, (i > 3) ? 3 : i, i);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        mode = 1'b0; lane_en = 4'b1111; out_ready = 4'b0000;
        in_valid = 1'b1; in_data = 8'hE1;
        tick();
        in_data = 8'hE2;
        tick();
        in_valid = 1'b0;
        #1;
        total++;
        if (busy !== 1'b1 || out_valid !== 4'b0001) begin
            bad++;
            $display("FAIL pre_reset_full: busy=%b ov=%b", busy, out_valid);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 4'b0000 || busy !== 1'b0 || lane_sel !== 2'd0) begin
            bad++;
            $display("FAIL async_reset: ov=%b busy=%b sel=%0d want 0",
                     out_valid, busy, lane_sel);
        end
        tick();
        rst_n = 1'b1;
        out_ready = 4'b1111;
        in_valid = 1'b1; in_data = 8'hE3;
        tick();
        total++;
        if (out_valid !== 4'b0001 || out_data !== 8'hE3) begin
            bad++;
            $display("FAIL post_reset_grant: ov=%b data=%h want 0001/e3",
                     out_valid, out_data);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int held;
        int hlane;
        int hdata;
        int ptr;
        int drops;
        int exp_rdy;
        int do_load;
        int lane;
        do_reset();
        held = 0; hlane = 0; hdata = 0; ptr = 3; drops = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_dest   = 2'($urandom);
            mode      = 1'($urandom);
            lane_en   = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
            out_ready = 4'($urandom);
            #1;
            exp_rdy = ((held == 0 || out_ready[hlane]) &&
                       (mode || lane_en != 4'b0000)) ? 1 : 0;
            total++;
            if (in_ready !== 1'(exp_rdy)) begin
                bad++;
                $display("FAIL rnd_ready[%0d]: got=%b want=%0d", c, in_ready, exp_rdy);
            end
            do_load = 0;
            lane = 0;
            if (in_valid && exp_rdy == 1) begin
                if (!mode) begin
                    for (int k = 1; k <= 4; k++) begin
                        if (do_load == 0 && lane_en[(ptr + k) % 4]) begin
                            lane = (ptr + k) % 4;
                            do_load = 1;
                        end
                    end
                    ptr = lane;
                end else if (lane_en[in_dest]) begin
                    lane = int'(in_dest);
                    do_load = 1;
                end else begin
                    drops++;
                end
            end
            if (do_load == 1) begin
                held = 1; hlane = lane; hdata = int'(in_data);
            end else if (held == 1 && out_ready[hlane]) begin
                held = 0;
            end
            tick();
            total++;
            if (out_valid !== ((held == 1) ? (4'b0001 << hlane) : 4'b0000)
                || busy !== 1'(held) || out_valid2 !== out_valid
                || (held == 1 && (out_data !== 8'(hdata) || lane_sel !== 2'(hlane)))
                || drop_cnt !== 8'((drops > 255) ? 255 : drops)
                || drop_cnt2 !== 2'((drops > 3) ? 3 : drops)) begin
                bad++;
                $display("FAIL rnd_out[%0d]: ov=%b data=%h sel=%0d busy=%b drop=%0d want held=%0d lane=%0d data=%h drops=%0d",
                         c, out_valid, out_data, lane_sel, busy, drop_cnt,
                         held, hlane, hdata, drops);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_rr_sweep();
        test_masked_skip();
        test_backpressure();
        test_addressed_drop();
        test_drop_saturation();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_dispatcher.md
Name: demux_dispatcher

Overview:
Registered 1:4 stream dispatcher that sequences a 1:4 demux. It accepts words on a single valid/ready input stream and routes each word to exactly one of four output lanes. Lane choice is either round-robin over enabled lanes or addressed by a per-word destination tag. It sits between a single producer and four consumer lanes and owns the demux select.

Parameters:
WIDTH, 8, data word width in bits
CNTW, 8, width of the drop counter

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a word
in_ready  output  1  dispatcher accepts the word this cycle
in_data  input  WIDTH  word payload
in_dest  input  2  destination lane; used in addressed mode only
mode  input  1  0 = round-robin, 1 = addressed; sampled at acceptance
lane_en  input  4  per-lane enable mask; sampled at acceptance
out_valid  output  4  one-hot lane valid; all-zero when empty
out_ready  input  4  per-lane consumer ready
out_data  output  WIDTH  shared payload bus; meaningful only when out_valid is non-zero
lane_sel  output  2  lane of the held word (the demux select)
busy  output  1  holding register full
drop_cnt  output  CNTW  words dropped in addressed mode to disabled lanes; saturating

Behaviour:
- One-entry holding register with a 2-state FSM:
  - EMPTY -> FULL on accept of a routable word.
  - FULL -> EMPTY on drain without a simultaneous accept.
  - FULL -> FULL on drain with a simultaneous accept.
- Reset (async, rst_n=0):
  - FSM = EMPTY; out_valid=0, out_data=0, lane_sel=0, busy=0, drop_cnt=0.
  - RR pointer = 3, so the first round-robin grant is lane 0.
- Drain: occurs when out_valid[lane_sel]=1 and out_ready[lane_sel]=1.
- Accept: occurs when in_valid && in_ready.
- in_ready = (EMPTY || drain) && route_ok.
  - route_ok: mode=0 requires lane_en != 0; mode=1 is always 1.
  - in_ready is combinational from out_ready and lane_en. in_ready never depends on in_valid.
- Lane choice at accept:
  - mode=0: first enabled lane searching pointer+1, pointer+2, ... modulo 4. The pointer is updated to the chosen lane.
  - mode=1: lane = in_dest. The pointer is unchanged.
- Accept, latency and throughput:
  - A word accepted in cycle N appears on out_data/out_valid in cycle N+1; out_valid is one-hot at lane_sel.
  - Full throughput: drain and accept in the same cycle reload the register with no bubble.
- Addressed drop: mode=1 and lane_en[in_dest]=0.
  - The word is accepted (in_ready=1 under the normal rule) but not loaded.
  - drop_cnt increments, saturating at all-ones.
  - The register state follows the drain rule only.
- Hold stability: while FULL and not draining, out_data, lane_sel and out_valid hold constant, regardless of later changes to lane_en, mode, in_dest or out_ready on other lanes.
- Ready on other lanes: out_ready on non-selected lanes is ignored.
- Output registering: out_valid, out_data and lane_sel are registered; busy = FULL.
- lane_en all-zero in mode=0: in_ready=0; a held word still drains.
- Reset asserted mid-transfer: the held word is discarded, and outputs clear in the same cycle (asynchronously).

Test Plan:
1. Round-robin sweep: reset; mode=0, lane_en=4'b1111, all out_ready=1; stream 0x11,0x22,0x33,0x44,0x55 back-to-back. Required: lanes 0,1,2,3,0, one word per cycle from cycle 1, in_ready=1 throughout.
2. Masked skip: lane_en=4'b1010, stream 0xA0,0xA1,0xA2. Required: lanes 1,3,1; out_valid is 4'b0010, 4'b1000, 4'b0010.
3. Backpressure: out_ready[2]=0 and a word 0x5C routed to lane 2. Required:
   - busy=1, out_valid=4'b0100 and out_data=0x5C held stable for 5 cycles.
   - in_ready=0; toggling lane_en has no effect.
   - Raising out_ready[2] drains, and a pending word loads in the same cycle.
4. Addressed mode with drop: mode=1, lane_en=4'b0111; words (dest 3, 0xD3), (dest 1, 0xD1). Required: 0xD3 is dropped (drop_cnt=1, no out_valid); 0xD1 is on lane 1 the next cycle.
5. Drop saturation: CNTW=2; send 5 words to a disabled lane. Required: drop_cnt reads 1,2,3,3,3.
6. Async reset while FULL: deassert rst_n mid-cycle. Required: out_valid=0, busy=0 immediately; after release, the first mode=0 grant with lane_en=4'b1111 goes to lane 0.
